avalon_debounced_input_pio: RTL and testbench

- Parametrised Avalon-MM input PIO replacing the plain buttons/switches export ports on the Nios system.
- N channels of raw board inputs are synchronised, per-channel debounced and polarity-normalised.
- Press edges are captured in a write-1-to-clear register; a maskable level IRQ goes to the Nios.
- One instance drives KEY[3:0] and another drives SW[9:0].

---
 rtl/avalon_debounced_input_pio.sv | 165 ++++++++++++++++
 tb/tb_avalon_debounced_input_pio.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_debounced_input_pio.sv
// avalon_debounced_input_pio: Avalon-MM input PIO.
// Each board input is synchronised, debounced and edge-captured. The core
// raises a maskable level IRQ toward the Nios processor.

// One input channel: synchroniser chain, debounce counter and edge detector.
module avalon_debounced_input_pio_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter bit EDGE_BOTH       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic n_in,
    output logic s_out,
    output logic db_out,
    output logic ev_out
);
    // A width of at least 1 keeps elaboration sane long enough for the
    // configuration check in the top module to report a bad value.
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   dly_q, dly_d;
    logic                   s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign s_out  = s;
    assign db_out = db_q;
    // The delayed copy resets to the same value as db.
    // This prevents reset from producing a spurious edge.
    assign ev_out = EDGE_BOTH ? (db_q ^ dly_q) : (db_q & ~dly_q);

    // Shift the synchroniser and advance the stability counter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], n_in};
        cnt_d  = cnt_q;
        db_d   = db_q;
        dly_d  = db_q;
        if (s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            dly_q  <= dly_d;
        end
    end
endmodule

module avalon_debounced_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter bit EDGE_BOTH       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_export,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);
    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES must be at least 1");
        end
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("WIDTH must be in 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [WIDTH-1:0] n, s, db, ev;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             rd_acc, wr_acc, wr_mask, wr_edge;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    // Normalise polarity so that a pressed or active input reads as 1.
    assign n = in_export ^ {WIDTH{ACTIVE_LOW}};

    // Bits of writedata above WIDTH have no register behind them.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        avalon_debounced_input_pio_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .EDGE_BOTH      (EDGE_BOTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .n_in  (n[i]),
            .s_out (s[i]),
            .db_out(db[i]),
            .ev_out(ev[i])
        );
    end

    // Bus decode, register updates, read mux and IRQ level.
    // On a same-bit collision, a new capture event beats a write-1-to-clear.
    always_comb begin
        rd_acc  = chipselect & read;
        wr_acc  = chipselect & write;
        wr_mask = wr_acc && (address == 2'd1);
        wr_edge = wr_acc && (address == 2'd2);
        mask_d  = wr_mask ? writedata[WIDTH-1:0] : mask_q;
        cap_d   = ev | (cap_q & ~({WIDTH{wr_edge}} & writedata[WIDTH-1:0]));
        irq_d   = |(cap_q & mask_q);
        rd_word = '0;
        case (address)
            2'd0:    rd_word[WIDTH-1:0] = db;
            2'd1:    rd_word[WIDTH-1:0] = mask_q;
            2'd2:    rd_word[WIDTH-1:0] = cap_q;
            default: rd_word[WIDTH-1:0] = s;
        endcase
        readdata_d = rd_acc ? rd_word : 32'h0;
    end

    // Register file and bus output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_avalon_debounced_input_pio.sv
// Directed bench for avalon_debounced_input_pio.
// Instance A uses the KEY configuration and instance B the SW configuration:
// WIDTH=10, active-high inputs, both edge directions captured.
module tb_avalon_debounced_input_pio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_a = 4'hF;
    logic [9:0]  in_b = 10'h0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0, write = 1'b0, cs_a = 1'b0, cs_b = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    avalon_debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .ACTIVE_LOW(1'b1), .EDGE_BOTH(1'b0)) u_a (
        .clk(clk), .reset(reset), .in_export(in_a), .address(address),
        .chipselect(cs_a), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata_a), .irq(irq_a));

    avalon_debounced_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .ACTIVE_LOW(1'b0), .EDGE_BOTH(1'b1)) u_b (
        .clk(clk), .reset(reset), .in_export(in_b), .address(address),
        .chipselect(cs_b), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata_b), .irq(irq_b));

    // All tasks start and end at a falling edge.
    task automatic bus_rd(input bit sel_b, input logic [1:0] a, output logic [31:0] d);
        cs_a = !sel_b; cs_b = sel_b; read = 1'b1; address = a;
        @(negedge clk);
        d = sel_b ? rdata_b : rdata_a;
        cs_a = 1'b0; cs_b = 1'b0; read = 1'b0;
    endtask

    task automatic bus_wr(input bit sel_b, input logic [1:0] a, input logic [31:0] v);
        cs_a = !sel_b; cs_b = sel_b; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0; write = 1'b0; writedata = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; in_a = 4'hF; in_b = 10'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_a); end
        n_chk++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_idle_rdata: got %h want 0", rdata_a); end
        for (int a = 0; a < 4; a++) begin
            bus_rd(1'b0, 2'(a), d);
            n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b want 0", irq_a); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        // A 3-cycle glitch must not be accepted.
        in_a = 4'b1110;
        repeat (3) @(negedge clk);
        in_a = 4'hF;
        repeat (10) @(negedge clk);
        bus_rd(1'b0, 2'd0, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_data: got %h want 0", d); end
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %h want 0", d); end
        // A held press reaches DATA 6 cycles after the input edge.
        // Continuous reads show the value from one cycle earlier.
        in_a = 4'b1110; cs_a = 1'b1; read = 1'b1; address = 2'd0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_chk++;
            if (rdata_a !== ((k == 7) ? 32'h1 : 32'h0)) begin
                n_fail++; $display("FAIL press_data_t%0d: got %h want %h", k, rdata_a, (k == 7) ? 1 : 0);
            end
        end
        address = 2'd2;
        @(negedge clk);
        n_chk++; if (rdata_a !== 32'h1) begin n_fail++; $display("FAIL press_edge: got %h want 1", rdata_a); end
        cs_a = 1'b0; read = 1'b0;
        bus_wr(1'b0, 2'd2, 32'h1);
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_bit0: got %h want 0", d); end
    endtask

    task automatic test_mask_clear();
        logic [31:0] d;
        in_a = 4'b1010;
        repeat (10) @(negedge clk);
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL unmasked_edge: got %h want 4", d); end
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL masked_irq: got %b want 0", irq_a); end
        bus_wr(1'b0, 2'd1, 32'h4);
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq_a); end
        @(negedge clk);
        n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq_a); end
        bus_rd(1'b0, 2'd1, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL mask_read: got %h want 4", d); end
        bus_wr(1'b0, 2'd2, 32'h4);
        n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", irq_a); end
        @(negedge clk);
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", irq_a); end
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_cleared: got %h want 0", d); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        // A simultaneous read and write returns the pre-write MASK value.
        cs_a = 1'b1; read = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h6;
        @(negedge clk);
        d = rdata_a;
        cs_a = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL rw_prewrite: got %h want 4", d); end
        bus_rd(1'b0, 2'd1, d);
        n_chk++; if (d !== 32'h6) begin n_fail++; $display("FAIL rw_mask: got %h want 6", d); end
        // The bit1 capture event lands in the 7th cycle; the clear write is timed to hit the same cycle.
        in_a = 4'b1000;
        repeat (6) @(negedge clk);
        bus_wr(1'b0, 2'd2, 32'h2);
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins_edge: got %h want 2", d); end
        n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b want 1", irq_a); end
        repeat (3) @(negedge clk);
        n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq_hold: got %b want 1", irq_a); end
    endtask

    task automatic test_edge_both();
        logic [31:0] d;
        for (int ph = 0; ph < 2; ph++) begin
            in_b = (ph == 0) ? 10'h200 : 10'h000;
            cs_b = 1'b1; read = 1'b1; address = 2'd3;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                n_chk++;
                if (rdata_b !== (((k == 3) == (ph == 0)) ? 32'h200 : 32'h0)) begin
                    n_fail++; $display("FAIL raw_ph%0d_t%0d: got %h", ph, k, rdata_b);
                end
            end
            cs_b = 1'b0; read = 1'b0;
            repeat (8) @(negedge clk);
            bus_rd(1'b1, 2'd2, d);
            n_chk++; if (d !== 32'h200) begin n_fail++; $display("FAIL both_edge_ph%0d: got %h want 200", ph, d); end
            bus_rd(1'b1, 2'd0, d);
            n_chk++; if (d !== ((ph == 0) ? 32'h200 : 32'h0)) begin n_fail++; $display("FAIL both_data_ph%0d: got %h", ph, d); end
            bus_wr(1'b1, 2'd2, 32'h200);
            bus_rd(1'b1, 2'd2, d);
            n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL both_clear_ph%0d: got %h want 0", ph, d); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        in_a = 4'hF;
        repeat (10) @(negedge clk);
        bus_wr(1'b0, 2'd2, 32'hF);
        bus_rd(1'b0, 2'd0, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_pre_data: got %h want 0", d); end
        // Press bit3, then reset while its counter holds 2.
        in_a = 4'b0111;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cs_a = 1'b1; read = 1'b1; address = 2'd2;
        for (int k = 6; k <= 13; k++) begin
            @(negedge clk);
            n_chk++;
            if (rdata_a !== ((k == 13) ? 32'h8 : 32'h0)) begin
                n_fail++; $display("FAIL mid_edge_t%0d: got %h want %h", k, rdata_a, (k == 13) ? 8 : 0);
            end
        end
        cs_a = 1'b0; read = 1'b0;
        bus_rd(1'b0, 2'd0, d);
        n_chk++; if (d !== 32'h8) begin n_fail++; $display("FAIL mid_data: got %h want 8", d); end
        bus_wr(1'b0, 2'd2, 32'h8);
        repeat (8) @(negedge clk);
        bus_rd(1'b0, 2'd2, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_once: got %h want 0", d); end
        n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", irq_a); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_debounce();
        test_mask_clear();
        test_set_wins();
        test_edge_both();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
